// File: rtl/fft_fpu_pkg.sv
// Shared types and constants for the FP32 butterfly add/sub sequencer.
// Holds the state/phase encodings, op codes and the per-state FPU operand mux.
package fft_fpu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP0  = 3'd1,
    OP1  = 3'd2,
    OP2  = 3'd3,
    OP3  = 3'd4,
    DONE = 3'd5
  } bfly_state_e;

  typedef enum logic {
    ISSUE   = 1'b0,
    CAPTURE = 1'b1
  } bfly_phase_e;

  localparam logic        OP_ADD    = 1'b0;
  localparam logic        OP_SUB    = 1'b1;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } fpu_req_t;

  // Operand/op request the shared FPU sees in a given state; idle states drive zero.
  function automatic fpu_req_t fpu_req(input bfly_state_e st,
                                       input logic [31:0] a_re, input logic [31:0] a_im,
                                       input logic [31:0] b_re, input logic [31:0] b_im);
    fpu_req_t r;
    r = '{op: OP_ADD, a: FP32_ZERO, b: FP32_ZERO};
    case (st)
      OP0:     r = '{op: OP_ADD, a: a_re, b: b_re};
      OP1:     r = '{op: OP_ADD, a: a_im, b: b_im};
      OP2:     r = '{op: OP_SUB, a: a_re, b: b_re};
      OP3:     r = '{op: OP_SUB, a: a_im, b: b_im};
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_addsub_seq.sv
// Radix-2 butterfly y0 = a + b, y1 = a - b, time-multiplexed over one external FP32 add/sub.
// Define FFT_BFLY_FPU_RES_REG_EN to register the FPU request (two cycles per op: ISSUE, CAPTURE).
module fft_bfly_addsub_seq
  import fft_fpu_pkg::*;
#(
  parameter int NUM_OP = 1,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_32_a_re,
  input  logic [DATA_W-1:0] i_32_a_im,
  input  logic [DATA_W-1:0] i_32_b_re,
  input  logic [DATA_W-1:0] i_32_b_im,
  output logic [NUM_OP-1:0] o_fpu_add_sub,
  output logic [DATA_W-1:0] o_fpu_32_a,
  output logic [DATA_W-1:0] o_fpu_32_b,
  input  logic [DATA_W-1:0] i_fpu_32_s,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_32_y0_re,
  output logic [DATA_W-1:0] o_32_y0_im,
  output logic [DATA_W-1:0] o_32_y1_re,
  output logic [DATA_W-1:0] o_32_y1_im,
  output logic              o_busy
);

  bfly_state_e       state, state_nxt;
  logic [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic              accept;
  logic              op_done;
  fpu_req_t          fpu;

  assign o_ready = (state == IDLE) | ((state == DONE) & i_ready);
  assign accept  = i_valid & o_ready;
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);

`ifdef FFT_BFLY_FPU_RES_REG_EN
  bfly_phase_e phase, phase_nxt;

  assign op_done = (phase == CAPTURE);
`else
  assign op_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = OP0;
      OP0:     if (op_done) state_nxt = OP1;
      OP1:     if (op_done) state_nxt = OP2;
      OP2:     if (op_done) state_nxt = OP3;
      OP3:     if (op_done) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = i_valid ? OP0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operands are held by upstream until accepted; no reset needed on data.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_re <= i_32_a_re;
      a_im <= i_32_a_im;
      b_re <= i_32_b_re;
      b_im <= i_32_b_im;
    end
  end

`ifdef FFT_BFLY_FPU_RES_REG_EN
  always_comb begin
    phase_nxt = ISSUE;
    if ((state_nxt == state) && (state != IDLE) && (state != DONE))
      phase_nxt = (phase == ISSUE) ? CAPTURE : ISSUE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) phase <= ISSUE;
    else       phase <= phase_nxt;
  end

  // Request for the upcoming state is registered so it is stable across ISSUE and CAPTURE.
  always_ff @(posedge i_clk) begin
    if (i_rst) fpu <= '0;
    else       fpu <= fpu_req(state_nxt,
                              accept ? i_32_a_re : a_re, accept ? i_32_a_im : a_im,
                              accept ? i_32_b_re : b_re, accept ? i_32_b_im : b_im);
  end
`else
  assign fpu = fpu_req(state, a_re, a_im, b_re, b_im);
`endif

  assign o_fpu_add_sub = NUM_OP'(fpu.op);
  assign o_fpu_32_a    = fpu.a;
  assign o_fpu_32_b    = fpu.b;

  // Result capture at the end of each op's final cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_32_y0_re <= '0;
      o_32_y0_im <= '0;
      o_32_y1_re <= '0;
      o_32_y1_im <= '0;
    end else if (op_done) begin
      case (state)
        OP0:     o_32_y0_re <= i_fpu_32_s;
        OP1:     o_32_y0_im <= i_fpu_32_s;
        OP2:     o_32_y1_re <= i_fpu_32_s;
        OP3:     o_32_y1_im <= i_fpu_32_s;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bfly_addsub_seq.sv
// Bench for fft_bfly_addsub_seq: closes the loop with a behavioural FP32 add/sub model.
// Honours FFT_BFLY_FPU_RES_REG_EN (two cycles per op, latency 9) when defined.
module tb_fft_bfly_addsub_seq;

`ifdef FFT_BFLY_FPU_RES_REG_EN
  localparam int OPC = 2;
`else
  localparam int OPC = 1;
`endif
  localparam int LAT = 4 * OPC + 1;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic [0:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_s;
  logic [31:0] y0_re, y0_im, y1_re, y1_im;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a_re, a_im, b_re, b_im;
    logic [31:0] y0_re, y0_im, y1_re, y1_im;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  fft_bfly_addsub_seq #(.NUM_OP(1), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_32_a_re(a_re), .i_32_a_im(a_im), .i_32_b_re(b_re), .i_32_b_im(b_im),
    .o_fpu_add_sub(fpu_op), .o_fpu_32_a(fpu_a), .o_fpu_32_b(fpu_b), .i_fpu_32_s(fpu_s),
    .o_valid(out_valid), .i_ready(in_ready),
    .o_32_y0_re(y0_re), .o_32_y0_im(y0_im), .o_32_y1_re(y1_re), .o_32_y1_im(y1_im),
    .o_busy(busy)
  );

  function automatic real fp2r(input logic [31:0] x);
    real v;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    while (e > 127) begin v = v * 2.0; e--; end
    while (e < 127) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub);
    logic [31:0] bb;
    bb = {b[31] ^ sub, b[30:0]};
    if (a[30:23] == 8'hFF) return a;
    if (bb[30:23] == 8'hFF) return bb;
    return r2fp(fp2r(a) + fp2r(bb));
  endfunction

  always_comb fpu_s = fp_addsub(fpu_a, fpu_b, fpu_op[0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    a_re = vecs[i].a_re;
    a_im = vecs[i].a_im;
    b_re = vecs[i].b_re;
    b_im = vecs[i].b_im;
  endtask

  task automatic check_y(input int i);
    chk($sformatf("y0_re[%0d]", i), y0_re, vecs[i].y0_re);
    chk($sformatf("y0_im[%0d]", i), y0_im, vecs[i].y0_im);
    chk($sformatf("y1_re[%0d]", i), y1_re, vecs[i].y1_re);
    chk($sformatf("y1_im[%0d]", i), y1_im, vecs[i].y1_im);
  endtask

  // Called one cycle after the accepting edge; returns cycles until o_valid and op-sequence errors.
  task automatic run_wait(input int vi, output int cyc, output int seq_err);
    int k;
    cyc = 1;
    seq_err = 0;
    while (!out_valid && cyc < 40) begin
      if (cyc < LAT) begin
        k = (cyc - 1) / OPC;
        if (fpu_op[0] !== (k >= 2)) seq_err++;
        if (fpu_a !== ((k % 2) ? vecs[vi].a_im : vecs[vi].a_re)) seq_err++;
        if (fpu_b !== ((k % 2) ? vecs[vi].b_im : vecs[vi].b_re)) seq_err++;
      end else begin
        seq_err++;
      end
      tick();
      cyc++;
    end
  endtask

  initial begin
    int          cyc, se;
    logic [31:0] h0, h1;

    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000,
                32'h3FC00000, 32'h40100000, 32'h3F000000, 32'h3FE00000};
    vecs[1] = '{32'h40400000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
                32'h40800000, 32'h00000000, 32'h40000000, 32'hC0000000};
    vecs[2] = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h00000000,
                32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000};
    vecs[3] = '{32'h41200000, 32'h3F000000, 32'hC0000000, 32'h40800000,
                32'h41000000, 32'h40900000, 32'h41400000, 32'hC0600000};

    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_y0_re", y0_re, 32'h0);
    chk("rst_y1_im", y1_im, 32'h0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      drive(i);
      in_valid = 1'b1;
      chk($sformatf("ready_idle[%0d]", i), 32'(out_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      run_wait(i, cyc, se);
      chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(LAT));
      chk($sformatf("opseq[%0d]", i), 32'(se), 32'd0);
      check_y(i);
      chk($sformatf("fpu_done_a[%0d]", i), fpu_a, 32'h0);
      tick();
      chk($sformatf("valid_after[%0d]", i), 32'(out_valid), 32'd0);
      chk($sformatf("busy_after[%0d]", i), 32'(busy), 32'd0);
    end

    // Backpressure: results and o_valid held while downstream stalls.
    drive(1);
    in_valid = 1'b1;
    in_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    run_wait(1, cyc, se);
    chk("hold_latency", 32'(cyc), 32'(LAT));
    h0 = y0_re;
    h1 = y1_im;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold_valid[%0d]", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold_ready[%0d]", c), 32'(out_ready), 32'd0);
      chk($sformatf("hold_y0_re[%0d]", c), y0_re, h0);
      chk($sformatf("hold_y1_im[%0d]", c), y1_im, h1);
      chk($sformatf("hold_fpu_a[%0d]", c), fpu_a, 32'h0);
      chk($sformatf("hold_fpu_op[%0d]", c), 32'(fpu_op), 32'd0);
      tick();
    end
    check_y(1);
    in_ready = 1'b1;
    tick();
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);

    // Back-to-back: second butterfly accepted in the DONE cycle.
    drive(0);
    in_valid = 1'b1;
    tick();
    drive(3);
    run_wait(0, cyc, se);
    chk("b2b_lat0", 32'(cyc), 32'(LAT));
    check_y(0);
    chk("b2b_ready_done", 32'(out_ready), 32'd1);
    tick();
    chk("b2b_valid_gap", 32'(out_valid), 32'd0);
    run_wait(3, cyc, se);
    chk("b2b_lat1", 32'(cyc + LAT), 32'(2 * LAT));
    chk("b2b_opseq1", 32'(se), 32'd0);
    check_y(3);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset during OP2 discards the partial butterfly.
    drive(3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2 * OPC) tick();
    chk("op2_op", 32'(fpu_op), 32'd1);
    chk("op2_a", fpu_a, vecs[3].a_re);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_y0_re", y0_re, 32'h0);
    chk("mid_rst_y0_im", y0_im, 32'h0);
    chk("mid_rst_fpu_a", fpu_a, 32'h0);
    drive(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    run_wait(1, cyc, se);
    chk("post_rst_latency", 32'(cyc), 32'(LAT));
    chk("post_rst_opseq", 32'(se), 32'd0);
    check_y(1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
